axi2s_reg_bank: RTL and testbench

- Parametrised, multi-channel successor of the single-channel AXI-to-stream control/status register file.
- Holds per-channel DMA window, frame and TDD timing registers in shadow/active pairs. Active copies update atomically at a frame boundary or on a forced commit.
- Adds sticky write-1-to-clear (W1C) event status and a registered read port.
- Sits between the PS-side register bus bridge and the NCH AXI-to-stream DMA/timing engines.

---
 rtl/axi2s_reg_bank_pkg.sv | 61 ++++++
 rtl/axi2s_chan_regs.sv | 96 +++++++++
 rtl/axi2s_reg_bank.sv | 141 ++++++++++++++
 tb/tb_axi2s_reg_bank.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/axi2s_reg_bank_pkg.sv
// Shared constants and types for the multi-channel AXI-to-stream register bank.
// Register offsets, reset values, window geometry and STATUS bit indices.
package axi2s_reg_bank_pkg;

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATE  = 6'h04;
  localparam logic [5:0] OFF_STATUS = 6'h08;
  localparam logic [5:0] OFF_IBASE  = 6'h10;
  localparam logic [5:0] OFF_ISIZE  = 6'h14;
  localparam logic [5:0] OFF_OBASE  = 6'h18;
  localparam logic [5:0] OFF_OSIZE  = 6'h1C;
  localparam logic [5:0] OFF_FLEN   = 6'h20;
  localparam logic [5:0] OFF_FADJ   = 6'h24;
  localparam logic [5:0] OFF_TSTART = 6'h30;
  localparam logic [5:0] OFF_TEND   = 6'h34;
  localparam logic [5:0] OFF_RSTART = 6'h38;
  localparam logic [5:0] OFF_REND   = 6'h3C;

  localparam logic [5:0] OFF_VERSION  = 6'h00;
  localparam logic [5:0] OFF_COMMIT   = 6'h04;
  localparam logic [5:0] OFF_IRQ_MASK = 6'h08;

  localparam logic [7:0] CH_STRIDE = 8'h40;
  localparam logic [7:0] GLB_OFF   = 8'hC0;

  localparam int ST_OVR = 0;
  localparam int ST_UND = 1;
  localparam int ST_AXI = 2;

  localparam logic [31:0] RST_IBASE = 32'hfffc0000;
  localparam logic [31:0] RST_OBASE = 32'hfffd0000;
  localparam logic [17:0] RST_SIZE  = 18'h400;
  localparam logic [23:0] RST_FLEN  = 24'd1920;
  localparam logic [23:0] RST_TEND  = 24'd1919;

  typedef struct packed {
    logic        ien;
    logic        oen;
    logic        tdd;
    logic [31:0] ibase;
    logic [17:0] isize;
    logic [31:0] obase;
    logic [17:0] osize;
    logic [23:0] flen;
    logic [23:0] fadj;
    logic [23:0] tstart;
    logic [23:0] tend;
    logic [23:0] rstart;
    logic [23:0] rend;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    ien: 1'b0, oen: 1'b0, tdd: 1'b0,
    ibase: RST_IBASE, isize: RST_SIZE,
    obase: RST_OBASE, osize: RST_SIZE,
    flen: RST_FLEN, fadj: 24'd0,
    tstart: 24'd0, tend: RST_TEND,
    rstart: 24'd0, rend: RST_TEND
  };

endpackage

// File: rtl/axi2s_chan_regs.sv
// One channel: shadow/active config pair, pending flag, sticky W1C status.
// Read data is the combinational view of this channel's window at off.
module axi2s_chan_regs
  import axi2s_reg_bank_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr,
  input  logic [5:0]  off,
  input  logic [31:0] din,
  input  logic        force_commit,
  input  logic        frame_sync,
  input  logic [2:0]  evt,
  output cfg_t        act,
  output logic        pending,
  output logic [2:0]  status,
  output logic [31:0] rdata
);

  cfg_t       shd;
  cfg_t       shd_nxt;
  logic       rw_wr;
  logic [2:0] clr;
  logic       commit;

  assign commit = pending & (frame_sync | force_commit);
  assign clr    = (wr && off == OFF_STATUS) ? din[2:0] : 3'b000;

  // Shadow write decode; only RW registers mark the channel pending.
  always_comb begin
    shd_nxt = shd;
    rw_wr   = 1'b0;
    if (wr) begin
      rw_wr = 1'b1;
      case (off)
        OFF_CTRL: begin
          shd_nxt.ien = din[0];
          shd_nxt.oen = din[1];
          shd_nxt.tdd = din[2];
        end
        OFF_IBASE:  shd_nxt.ibase  = din;
        OFF_ISIZE:  shd_nxt.isize  = din[23:6];
        OFF_OBASE:  shd_nxt.obase  = din;
        OFF_OSIZE:  shd_nxt.osize  = din[23:6];
        OFF_FLEN:   shd_nxt.flen   = din[23:0];
        OFF_FADJ:   shd_nxt.fadj   = din[23:0];
        OFF_TSTART: shd_nxt.tstart = din[23:0];
        OFF_TEND:   shd_nxt.tend   = din[23:0];
        OFF_RSTART: shd_nxt.rstart = din[23:0];
        OFF_REND:   shd_nxt.rend   = din[23:0];
        default:    rw_wr = 1'b0;
      endcase
    end
  end

  // Commit copies the pre-write shadow; a same-cycle write keeps pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shd     <= CFG_RST;
      act     <= CFG_RST;
      pending <= 1'b0;
      status  <= 3'b000;
    end else begin
      shd <= shd_nxt;
      if (commit)
        act <= shd;
      if (rw_wr)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;
      status <= (status & ~clr) | evt;
    end
  end

  // Window read view: shadow for RW registers.
  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL:   rdata[2:0] = {shd.tdd, shd.oen, shd.ien};
      OFF_STATE:  rdata[3:0] = {pending, act.tdd, act.oen, act.ien};
      OFF_STATUS: rdata[2:0] = status;
      OFF_IBASE:  rdata = shd.ibase;
      OFF_ISIZE:  rdata[23:6] = shd.isize;
      OFF_OBASE:  rdata = shd.obase;
      OFF_OSIZE:  rdata[23:6] = shd.osize;
      OFF_FLEN:   rdata[23:0] = shd.flen;
      OFF_FADJ:   rdata[23:0] = shd.fadj;
      OFF_TSTART: rdata[23:0] = shd.tstart;
      OFF_TEND:   rdata[23:0] = shd.tend;
      OFF_RSTART: rdata[23:0] = shd.rstart;
      OFF_REND:   rdata[23:0] = shd.rend;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/axi2s_reg_bank.sv
// Multi-channel AXI-to-stream register bank: decode, globals, read port, irq.
// Optional AXI2S_IRQ_EN adds IRQ_MASK at C8 and a registered irq output.
module axi2s_reg_bank
  import axi2s_reg_bank_pkg::*;
#(
  parameter logic [17:0] BASE = 18'h01000,
  parameter int          NCH  = 2,
  parameter logic [31:0] VER  = 32'h0002_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wen,
  input  logic [17:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              rvalid,
  input  logic [NCH-1:0]    frame_sync,
  input  logic [3*NCH-1:0]  evt,
  output logic [NCH-1:0]    ien,
  output logic [NCH-1:0]    oen,
  output logic [NCH-1:0]    tddmode,
  output logic [32*NCH-1:0] ibase,
  output logic [32*NCH-1:0] obase,
  output logic [18*NCH-1:0] isize,
  output logic [18*NCH-1:0] osize,
  output logic [24*NCH-1:0] frame_len,
  output logic [24*NCH-1:0] frame_adj,
  output logic [24*NCH-1:0] tstart,
  output logic [24*NCH-1:0] tend,
  output logic [24*NCH-1:0] rstart,
  output logic [24*NCH-1:0] rend,
  output logic [NCH-1:0]    pending,
  output logic              irq
);

  logic             hit;
  logic [1:0]       ch;
  logic [5:0]       off;
  logic             glb;
  logic             wr;
  logic             rd;
  logic [NCH-1:0]   commit_vec;
  logic [3*NCH-1:0] status_all;
  logic [31:0]      rdata;
  logic [31:0]      rd_ch [NCH];
  cfg_t             act [NCH];
  logic             unused_addr;

  assign unused_addr = &{1'b0, addr[1:0]};
  assign hit = addr[17:8] == BASE[17:8];
  assign ch  = addr[7:6];
  assign off = {addr[5:2], 2'b00};
  assign glb = ch == GLB_OFF[7:6];
  assign wr  = en & wen & hit;
  assign rd  = en & ~wen;

  assign commit_vec = (wr && glb && off == OFF_COMMIT)
                    ? din[NCH-1:0] : '0;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    axi2s_chan_regs u_ch (
      .clk          (clk),
      .rst          (rst),
      .wr           (wr && ch == 2'(c)),
      .off          (off),
      .din          (din),
      .force_commit (commit_vec[c]),
      .frame_sync   (frame_sync[c]),
      .evt          (evt[3*c +: 3]),
      .act          (act[c]),
      .pending      (pending[c]),
      .status       (status_all[3*c +: 3]),
      .rdata        (rd_ch[c])
    );
    assign ien[c]             = act[c].ien;
    assign oen[c]             = act[c].oen;
    assign tddmode[c]         = act[c].tdd;
    assign ibase[32*c +: 32]  = act[c].ibase;
    assign obase[32*c +: 32]  = act[c].obase;
    assign isize[18*c +: 18]  = act[c].isize;
    assign osize[18*c +: 18]  = act[c].osize;
    assign frame_len[24*c +: 24] = act[c].flen;
    assign frame_adj[24*c +: 24] = act[c].fadj;
    assign tstart[24*c +: 24] = act[c].tstart;
    assign tend[24*c +: 24]   = act[c].tend;
    assign rstart[24*c +: 24] = act[c].rstart;
    assign rend[24*c +: 24]   = act[c].rend;
  end

`ifdef AXI2S_IRQ_EN
  logic [3*NCH-1:0] mask;

  // IRQ mask register and registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      if (wr && glb && off == OFF_IRQ_MASK)
        mask <= din[3*NCH-1:0];
      irq <= |(status_all & mask);
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Read mux: globals, in-range channel windows, zero elsewhere.
  always_comb begin
    rdata = '0;
    if (hit) begin
      if (glb) begin
        case (off)
          OFF_VERSION:  rdata = VER;
`ifdef AXI2S_IRQ_EN
          OFF_IRQ_MASK: rdata[3*NCH-1:0] = mask;
`endif
          default:      rdata = '0;
        endcase
      end else begin
        for (int c = 0; c < NCH; c++)
          if (ch == 2'(c))
            rdata = rd_ch[c];
      end
    end
  end

  // Registered read port; dout holds when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd;
      if (rd)
        dout <= rdata;
    end
  end

endmodule

// File: tb/tb_axi2s_reg_bank.sv
// Directed self-checking bench for axi2s_reg_bank (NCH=2, default BASE).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_axi2s_reg_bank;

  localparam int NCH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              wen = 1'b0;
  logic [17:0]       addr = '0;
  logic [31:0]       din = '0;
  logic [31:0]       dout;
  logic              rvalid;
  logic [NCH-1:0]    frame_sync = '0;
  logic [3*NCH-1:0]  evt = '0;
  logic [NCH-1:0]    ien, oen, tddmode, pending;
  logic [32*NCH-1:0] ibase, obase;
  logic [18*NCH-1:0] isize, osize;
  logic [24*NCH-1:0] frame_len, frame_adj, tstart, tend, rstart, rend;
  logic              irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rdv;
  logic        rvv;

  always #5 clk = ~clk;

  axi2s_reg_bank dut (
    .clk(clk), .rst(rst), .en(en), .wen(wen), .addr(addr), .din(din),
    .dout(dout), .rvalid(rvalid), .frame_sync(frame_sync), .evt(evt),
    .ien(ien), .oen(oen), .tddmode(tddmode),
    .ibase(ibase), .obase(obase), .isize(isize), .osize(osize),
    .frame_len(frame_len), .frame_adj(frame_adj),
    .tstart(tstart), .tend(tend), .rstart(rstart), .rend(rend),
    .pending(pending), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [17:0] a, input logic [31:0] d);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = a; din = d;
    @(negedge clk);
    en = 1'b0; wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [17:0] a, output logic [31:0] d,
                        output logic v);
    @(negedge clk);
    en = 1'b1; wen = 1'b0; addr = a;
    @(negedge clk);
    en = 1'b0;
    d = dout; v = rvalid;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_flen0", 32'(frame_len[23:0]), 32'd1920);
    check("rst_ibase0", ibase[31:0], 32'hfffc0000);
    rst = 1'b0;

    bus_rd(18'h01054, rdv, rvv);
    check("rd_isize1", rdv, 32'h0001_0000);
    check("rd_isize1_v", 32'(rvv), 32'd1);
    check("tend1_rst", 32'(tend[47:24]), 32'd1919);
    @(negedge clk);
    check("rvalid_drop", 32'(rvalid), 32'd0);
    check("dout_hold", dout, 32'h0001_0000);

    bus_wr(18'h01020, 32'd2048);
    check("flen0_shadow_only", 32'(frame_len[23:0]), 32'd1920);
    check("pend0_set", 32'(pending), 32'b01);
    bus_rd(18'h01020, rdv, rvv);
    check("rd_flen0_shd", rdv, 32'd2048);
    @(negedge clk); frame_sync = 2'b01;
    @(negedge clk); frame_sync = 2'b00;
    check("flen0_commit", 32'(frame_len[23:0]), 32'd2048);
    check("pend0_clr", 32'(pending), 32'b00);

    bus_wr(18'h01074, 32'd100);
    check("pend1_set", 32'(pending), 32'b10);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = 18'h01070; din = 32'd5;
    frame_sync = 2'b10;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; frame_sync = 2'b00;
    check("wc_tend1", 32'(tend[47:24]), 32'd100);
    check("wc_tstart1", 32'(tstart[47:24]), 32'd0);
    check("wc_pend1", 32'(pending), 32'b10);

    bus_wr(18'h010C4, 32'h2);
    check("fc_tstart1", 32'(tstart[47:24]), 32'd5);
    check("fc_pend1", 32'(pending), 32'b00);
    bus_wr(18'h010C4, 32'h1);
    check("fc_nop_flen0", 32'(frame_len[23:0]), 32'd2048);
    check("fc_nop_pend", 32'(pending), 32'b00);

    bus_wr(18'h01000, 32'h5);
    bus_rd(18'h01004, rdv, rvv);
    check("state0_pend", rdv, 32'h8);
    bus_wr(18'h010C4, 32'h1);
    check("ctrl0_act", 32'({tddmode[0], oen[0], ien[0]}), 32'h5);
    bus_rd(18'h01004, rdv, rvv);
    check("state0_act", rdv, 32'h5);

    @(negedge clk); evt = 6'b001000;
    @(negedge clk); evt = 6'b000000;
    bus_rd(18'h01048, rdv, rvv);
    check("st1_set", rdv, 32'h1);
    @(negedge clk);
    en = 1'b1; wen = 1'b1; addr = 18'h01048; din = 32'h1;
    evt = 6'b001000;
    @(negedge clk);
    en = 1'b0; wen = 1'b0; evt = 6'b000000;
    bus_rd(18'h01048, rdv, rvv);
    check("st1_set_wins", rdv, 32'h1);
    bus_wr(18'h01048, 32'h1);
    bus_rd(18'h01048, rdv, rvv);
    check("st1_clr", rdv, 32'h0);
    check("st_no_pend", 32'(pending), 32'b00);

    bus_rd(18'h010C0, rdv, rvv);
    check("rd_version", rdv, 32'h0002_0000);
    bus_rd(18'h01080, rdv, rvv);
    check("rd_ch2_zero", rdv, 32'h0);
    check("rd_ch2_v", 32'(rvv), 32'd1);
    bus_rd(18'h010C0, rdv, rvv);
    bus_rd(18'h02000, rdv, rvv);
    check("rd_win_zero", rdv, 32'h0);
    check("rd_win_v", 32'(rvv), 32'd1);
    bus_wr(18'h02010, 32'h1234_5678);
    check("wr_win_nopend", 32'(pending), 32'b00);
    bus_rd(18'h01010, rdv, rvv);
    check("wr_win_ibase0", rdv, 32'hfffc0000);

`ifdef AXI2S_IRQ_EN
    bus_wr(18'h010C8, 32'h1);
    @(negedge clk); evt = 6'b000001;
    @(negedge clk); evt = 6'b000000;
    check("irq_lat0", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'd1);
`else
    bus_rd(18'h010C0, rdv, rvv);
    bus_rd(18'h010C8, rdv, rvv);
    check("rd_mask_absent", rdv, 32'h0);
    @(negedge clk); evt = 6'b000001;
    @(negedge clk); evt = 6'b000000;
    @(negedge clk);
    check("irq_tied", 32'(irq), 32'd0);
`endif

    bus_wr(18'h01010, 32'h1234_5678);
    check("pre_rst_pend", 32'(pending), 32'b01);
    bus_rd(18'h010C0, rdv, rvv);
    #2 rst = 1'b1;
    #1;
    check("arst_pend", 32'(pending), 32'b00);
    check("arst_dout", dout, 32'h0);
    check("arst_flen0", 32'(frame_len[23:0]), 32'd1920);
    check("arst_ien", 32'(ien), 32'b00);
    @(negedge clk); rst = 1'b0;
    bus_rd(18'h01010, rdv, rvv);
    check("arst_shd_ibase0", rdv, 32'hfffc0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
